// File: rtl/riscv_instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : riscv_instr_prefetch_queue
// Brief    : Instruction prefetch front end with a small word FIFO, branch
//            redirect/flush and aborted-response discard.
//            Optional macro RISCV_PF_BYPASS_EN: an empty FIFO forwards the
//            bus response to the IF stage in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_instr_prefetch_queue #(
    parameter int DEPTH       = 4,
    parameter int RDATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_i,
    input  logic                   branch_i,
    input  logic [31:0]            addr_i,
    input  logic                   ready_i,
    output logic                   valid_o,
    output logic [RDATA_WIDTH-1:0] rdata_o,
    output logic [31:0]            addr_o,
    output logic                   instr_req_o,
    output logic [31:0]            instr_addr_o,
    input  logic                   instr_gnt_i,
    input  logic                   instr_rvalid_i,
    input  logic [RDATA_WIDTH-1:0] instr_rdata_i,
    output logic                   busy_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_GNT     = 2'd1,
        WAIT_RVALID  = 2'd2,
        WAIT_ABORTED = 2'd3
    } state_t;

    state_t                 r_state;
    logic [31:0]            r_fetch_addr;
    logic [31:0]            r_rsp_addr;
    logic [RDATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [31:0]            r_mem_addr [DEPTH];
    logic [c_PTR_W-1:0]     r_wptr;
    logic [c_PTR_W-1:0]     r_rptr;
    logic [c_CNT_W-1:0]     r_count;

    logic               w_empty;
    logic               w_rsp_ok;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_count_next;
    logic               w_unused;

    assign w_unused = ^addr_i[1:0];
    assign w_empty  = (r_count == '0);
    // A response is only kept when it belongs to a live, non-redirected fetch.
    assign w_rsp_ok = (r_state == WAIT_RVALID) && instr_rvalid_i && !branch_i;

`ifdef RISCV_PF_BYPASS_EN
    assign w_bypass = w_rsp_ok && w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign valid_o = !branch_i && (!w_empty || w_bypass);
    assign rdata_o = w_bypass ? instr_rdata_i : (w_empty ? '0 : r_mem_data[r_rptr]);
    assign addr_o  = w_bypass ? r_rsp_addr    : (w_empty ? '0 : r_mem_addr[r_rptr]);

    assign w_pop  = valid_o && ready_i && !w_empty;
    assign w_push = w_rsp_ok && !(w_bypass && ready_i);
    assign w_count_next = r_count + {{(c_CNT_W-1){1'b0}}, w_push}
                                  - {{(c_CNT_W-1){1'b0}}, w_pop};

    assign instr_req_o  = (r_state == WAIT_GNT);
    assign instr_addr_o = r_fetch_addr;
    assign busy_o       = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_fetch_addr <= '0;
            r_rsp_addr   <= '0;
        end else if (branch_i) begin
            r_fetch_addr <= {addr_i[31:2], 2'b00};
            case (r_state)
                IDLE:     r_state <= WAIT_GNT;
                // A grant in the redirect cycle still belongs to the old address.
                WAIT_GNT: r_state <= instr_gnt_i ? WAIT_ABORTED : WAIT_GNT;
                default:  r_state <= instr_rvalid_i ? WAIT_GNT : WAIT_ABORTED;
            endcase
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_i && (r_count < c_DEPTH)) begin
                        r_state <= WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (instr_gnt_i) begin
                        r_rsp_addr   <= r_fetch_addr;
                        r_fetch_addr <= r_fetch_addr + 32'd4;
                        r_state      <= WAIT_RVALID;
                    end
                end
                WAIT_RVALID: begin
                    if (instr_rvalid_i) begin
                        r_state <= (req_i && (w_count_next < c_DEPTH)) ? WAIT_GNT : IDLE;
                    end
                end
                default: begin
                    if (instr_rvalid_i) begin
                        r_state <= WAIT_GNT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (branch_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= instr_rdata_i;
            r_mem_addr[r_wptr] <= r_rsp_addr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_instr_prefetch_queue
// Brief    : Directed and randomized bench with a bus responder and an
//            in-order stream scoreboard for riscv_instr_prefetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_instr_prefetch_queue;

    localparam int c_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i;
    logic        branch_i;
    logic [31:0] addr_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] rdata_o;
    logic [31:0] addr_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        busy_o;

    riscv_instr_prefetch_queue #(
        .DEPTH       (c_DEPTH),
        .RDATA_WIDTH (32)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .addr_i         (addr_i),
        .ready_i        (ready_i),
        .valid_o        (valid_o),
        .rdata_o        (rdata_o),
        .addr_o         (addr_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Stimulus knobs
    int          gnt_mode;    // 0 never, 1 always, 2 random
    int          ready_mode;  // 0 low, 1 high, 2 random
    int          lat_fixed;
    bit          lat_rand;
    bit          br_now;
    logic [31:0] br_addr;
    bit          junk_next;

    // Bus responder and scoreboard state
    bit          pend;
    logic [31:0] pend_addr;
    int          lat;
    logic [31:0] gnt_q[$];
    int          n_acc;
    int          n_rv;
    logic [31:0] exp_addr;
    bit          prev_req_hold;
    logic [31:0] prev_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0000_0093;
    endfunction

    // One clock cycle: drive at negedge, observe 2ns later, update models.
    task automatic step();
        @(negedge clk);
        instr_gnt_i = 1'b0;
        if (instr_req_o && !pend) begin
            instr_gnt_i = (gnt_mode == 1) || (gnt_mode == 2 && $urandom_range(0, 1) == 1);
        end
        instr_rvalid_i = pend && (lat == 0);
        instr_rdata_i  = instr_rvalid_i ? (junk_next ? 32'h0000_DEAD : mem_word(pend_addr)) : 32'h0;
        ready_i  = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 2) != 0);
        branch_i = br_now;
        addr_i   = br_addr;
        #2;
        if (prev_req_hold) begin
            check("req_hold", 32'(instr_req_o), 32'd1);
            check("addr_hold", instr_addr_o, prev_addr);
        end
        if (valid_o && ready_i) begin
            check("sb_addr", addr_o, exp_addr);
            check("sb_data", rdata_o, mem_word(exp_addr));
            exp_addr = exp_addr + 32'd4;
            n_acc++;
        end
        if (branch_i) exp_addr = {addr_i[31:2], 2'b00};
        if (instr_rvalid_i) begin
            pend      = 1'b0;
            junk_next = 1'b0;
            n_rv++;
        end else if (pend) begin
            lat--;
        end
        if (instr_gnt_i) begin
            pend      = 1'b1;
            pend_addr = instr_addr_o;
            lat       = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
            gnt_q.push_back(instr_addr_o);
        end
        prev_req_hold = instr_req_o && !instr_gnt_i && !branch_i;
        prev_addr     = instr_addr_o;
        br_now        = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        br_now  = 1'b1;
        br_addr = target;
        step();
    endtask

    initial begin
        int rv0;
        int acc0;
        int guard;
        rst_n = 1'b0; req_i = 1'b0; branch_i = 1'b0; addr_i = '0; ready_i = 1'b0;
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
        gnt_mode = 0; ready_mode = 0; lat_fixed = 0; lat_rand = 1'b0;
        br_now = 1'b0; br_addr = '0; junk_next = 1'b0;
        pend = 1'b0; pend_addr = '0; lat = 0; n_acc = 0; n_rv = 0;
        exp_addr = '0; prev_req_hold = 1'b0; prev_addr = '0;

        repeat (3) @(negedge clk);
        #2;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_addr", addr_o, 32'd0);
        check("rst_req", 32'(instr_req_o), 32'd0);
        check("rst_iaddr", instr_addr_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First fetch after redirect to an unaligned target
        req_i = 1'b1;
        redirect(32'h0000_0082);
        gnt_mode = 1;
        step();
        check("t1_req", 32'(instr_req_o), 32'd1);
        check("t1_iaddr", instr_addr_o, 32'h80);
        gnt_mode = 0;
        step();
`ifdef RISCV_PF_BYPASS_EN
        check("t1_valid", 32'(valid_o), 32'd1);
`else
        check("t1_valid_early", 32'(valid_o), 32'd0);
        step();
        check("t1_valid", 32'(valid_o), 32'd1);
`endif
        check("t1_addr", addr_o, 32'h80);
        check("t1_rdata", rdata_o, 32'h13);

        // Fill to credit limit with the IF stage stalled
        gnt_mode = 1;
        repeat (30) step();
        check("t2_grants", 32'(gnt_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < gnt_q.size(); i++) begin
            check("t2_gaddr", gnt_q[i], 32'h80 + 32'(4 * i));
        end
        check("t2_req", 32'(instr_req_o), 32'd0);
        check("t2_busy", 32'(busy_o), 32'd0);
        check("t2_valid", 32'(valid_o), 32'd1);
        check("t2_head", addr_o, 32'h80);
        check("t2_noacc", 32'(n_acc), 32'd0);
        ready_mode = 1;
        guard = 0;
        while ((n_acc < 4 || gnt_q.size() < 5) && guard < 60) begin
            step();
            guard++;
        end
        check("t2_pops", 32'(n_acc >= 4), 32'd1);
        check("t2_resume_cnt", 32'(gnt_q.size() >= 5), 32'd1);
        if (gnt_q.size() >= 5) check("t2_resume", gnt_q[4], 32'h90);

        // Redirect while a response is outstanding
        gnt_mode = 0;
        repeat (6) step();
        redirect(32'h84);
        gnt_mode = 1;
        lat_fixed = 2;
        step();
        check("t3_gnt", gnt_q[$], 32'h84);
        gnt_mode = 0;
        junk_next = 1'b1;
        rv0 = n_rv;
        redirect(32'h200);
        check("t3_busy", 32'(busy_o), 32'd1);
        guard = 0;
        while (n_rv == rv0 && guard < 10) begin
            step();
            check("t3_nojunk", 32'(valid_o), 32'd0);
            guard++;
        end
        check("t3_rv_seen", 32'(n_rv - rv0), 32'd1);
        step();
        check("t3_req", 32'(instr_req_o), 32'd1);
        check("t3_iaddr", instr_addr_o, 32'h200);

        // Grant withheld, redirect mid-wait
        redirect(32'h90);
        for (int c = 1; c <= 5; c++) begin
            if (c == 3) begin
                br_now  = 1'b1;
                br_addr = 32'h300;
            end
            step();
            check("t4_req", 32'(instr_req_o), 32'd1);
            check("t4_iaddr", instr_addr_o, (c <= 3) ? 32'h90 : 32'h300);
        end

        // Fetch address wrap
        redirect(32'hFFFF_FFFC);
        gnt_mode = 1;
        lat_fixed = 0;
        step();
        gnt_mode = 0;
        step();
        step();
        check("t5_req", 32'(instr_req_o), 32'd1);
        check("t5_iaddr", instr_addr_o, 32'h0);

        // Asynchronous reset with two buffered words and one response pending
        ready_mode = 0;
        redirect(32'h40);
        gnt_mode = 1;
        lat_fixed = 3;
        rv0 = n_rv;
        guard = 0;
        while (!((n_rv - rv0) >= 2 && pend) && guard < 40) begin
            step();
            guard++;
        end
        gnt_mode = 0;
        step();
        check("t6_pre_valid", 32'(valid_o), 32'd1);
        check("t6_pre_busy", 32'(busy_o), 32'd1);
        check("t6_pre_head", addr_o, 32'h40);
        rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(valid_o), 32'd0);
        check("t6_req", 32'(instr_req_o), 32'd0);
        check("t6_busy", 32'(busy_o), 32'd0);
        pend = 1'b0; junk_next = 1'b0; exp_addr = '0; prev_req_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the stream scoreboard
        gnt_mode = 2;
        ready_mode = 2;
        lat_rand = 1'b1;
        acc0 = n_acc;
        for (int k = 0; k < 3000; k++) begin
            req_i = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) begin
                br_now  = 1'b1;
                br_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
            end
            step();
        end
        check("rand_progress", 32'(n_acc - acc0 > 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
